// File: rtl/cnn_pkg.sv
// Shared definitions for the LeNet-5 accelerator: default BRAM geometry and the
// result-checker state encoding.
package cnn_pkg;

   localparam int unsigned CNN_DATA_W = 8;
   localparam int unsigned CNN_ADDR_W = 10;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } chk_state_t;

endpackage

// File: rtl/tol_cmp.sv
// Combinational word comparator: flags a mismatch when |a - b| exceeds tol, with
// a and b read as signed or unsigned words.
module tol_cmp
   import cnn_pkg::*;
#(
   parameter int unsigned DATA_W = CNN_DATA_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] tol,
   input  logic              signed_mode,
   output logic              mismatch
);

   logic [DATA_W:0] a_ext;
   logic [DATA_W:0] b_ext;
   logic [DATA_W:0] diff;
   logic [DATA_W:0] mag;

   // One extra bit holds the full difference range in either interpretation,
   // so the magnitude never overflows.
   always_comb begin
      a_ext    = {signed_mode & a[DATA_W-1], a};
      b_ext    = {signed_mode & b[DATA_W-1], b};
      diff     = a_ext - b_ext;
      mag      = diff[DATA_W] ? (~diff + 1'b1) : diff;
      mismatch = (mag > {1'b0, tol});
   end

endmodule

// File: rtl/bram_result_checker.sv
// Sweeps a result BRAM region against a golden BRAM region and reports the
// mismatch count, the first failing result address and a pass flag.
module bram_result_checker
   import cnn_pkg::*;
#(
   parameter int unsigned DATA_W = CNN_DATA_W,
   parameter int unsigned ADDR_W = CNN_ADDR_W,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] gold_base,
   input  logic [ADDR_W:0]   length,
   input  logic [DATA_W-1:0] tol,
   input  logic              signed_mode,
   output logic              res_en,
   output logic [ADDR_W-1:0] res_addr,
   input  logic [DATA_W-1:0] res_dout,
   output logic              gold_en,
   output logic [ADDR_W-1:0] gold_addr,
   input  logic [DATA_W-1:0] gold_dout,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_cnt,
   output logic              first_err_valid,
   output logic [ADDR_W-1:0] first_err_addr
);

   chk_state_t        state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [DATA_W-1:0] tol_q, tol_d;
   logic              sgn_q, sgn_d;
   logic              en_q, en_d;
   logic [ADDR_W-1:0] res_addr_q, res_addr_d;
   logic [ADDR_W-1:0] gold_addr_q, gold_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
   logic              fev_q, fev_d;
   logic [ADDR_W-1:0] fea_q, fea_d;

   // In-flight read tracking: bit/entry k describes the read issued k+1 cycles ago.
   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [RD_LAT:0]   vld_ext;
   logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];
   logic [ADDR_W-1:0] pipe_addr_d [RD_LAT];

   logic mismatch;
   logic cmp_hit;

   tol_cmp #(
      .DATA_W (DATA_W)
   ) u_tol_cmp (
      .a           (res_dout),
      .b           (gold_dout),
      .tol         (tol_q),
      .signed_mode (sgn_q),
      .mismatch    (mismatch)
   );

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      tol_d       = tol_q;
      sgn_d       = sgn_q;
      en_d        = en_q;
      res_addr_d  = res_addr_q;
      gold_addr_d = gold_addr_q;
      pass_d      = pass_q;
      err_cnt_d   = err_cnt_q;
      fev_d       = fev_q;
      fea_d       = fea_q;

      vld_ext        = {vld_q, en_q};
      vld_d          = vld_ext[RD_LAT-1:0];
      pipe_addr_d[0] = res_addr_q;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
         pipe_addr_d[k] = pipe_addr_q[k-1];
      end

      // Data of the oldest in-flight read is on the BRAM ports this cycle.
      cmp_hit = vld_q[RD_LAT-1] & mismatch;
      if (cmp_hit) begin
         err_cnt_d = err_cnt_q + 1'b1;
         if (!fev_q) begin
            fev_d = 1'b1;
            fea_d = pipe_addr_q[RD_LAT-1];
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               len_d       = length;
               tol_d       = tol;
               sgn_d       = signed_mode;
               idx_d       = '0;
               res_addr_d  = base_addr;
               gold_addr_d = gold_base;
               err_cnt_d   = '0;
               fev_d       = 1'b0;
               fea_d       = '0;
               pass_d      = 1'b0;
               if (length == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = READ;
                  en_d    = 1'b1;
               end
            end
         end
         READ: begin
            if (idx_q == len_q - 1'b1) begin
               state_d = DRAIN;
               en_d    = 1'b0;
            end else begin
               idx_d       = idx_q + 1'b1;
               res_addr_d  = res_addr_q + 1'b1;
               gold_addr_d = gold_addr_q + 1'b1;
            end
         end
         DRAIN: begin
            if (vld_d == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The final compare lands on the same edge that enters DONE.
      if (state_d == DONE) begin
         pass_d = (err_cnt_d == '0);
      end
      busy_d = (state_d == READ) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         tol_q       <= '0;
         sgn_q       <= 1'b0;
         en_q        <= 1'b0;
         res_addr_q  <= '0;
         gold_addr_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_cnt_q   <= '0;
         fev_q       <= 1'b0;
         fea_q       <= '0;
         vld_q       <= '0;
         for (int unsigned k = 0; k < RD_LAT; k++) begin
            pipe_addr_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         tol_q       <= tol_d;
         sgn_q       <= sgn_d;
         en_q        <= en_d;
         res_addr_q  <= res_addr_d;
         gold_addr_q <= gold_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_cnt_q   <= err_cnt_d;
         fev_q       <= fev_d;
         fea_q       <= fea_d;
         vld_q       <= vld_d;
         for (int unsigned k = 0; k < RD_LAT; k++) begin
            pipe_addr_q[k] <= pipe_addr_d[k];
         end
      end
   end

   assign res_en          = en_q;
   assign gold_en         = en_q;
   assign res_addr        = res_addr_q;
   assign gold_addr       = gold_addr_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_cnt         = err_cnt_q;
   assign first_err_valid = fev_q;
   assign first_err_addr  = fea_q;

endmodule

// File: tb/tb_bram_result_checker.sv
// Bench for bram_result_checker: two instances (read latency 1 and 3) share the
// stimulus and are checked against a table and a behavioural reference model.
module tb_bram_result_checker;

   localparam int DW = 8;
   localparam int AW = 10;
   localparam int NI = 2;
   localparam int MEMSZ = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] gold_base = '0;
   logic [AW:0]   length = '0;
   logic [DW-1:0] tol = '0;
   logic          signed_mode = 1'b0;

   logic          res_en_w [NI];
   logic          gold_en_w [NI];
   logic          busy_w [NI];
   logic          done_w [NI];
   logic          pass_w [NI];
   logic          fev_w [NI];
   logic [AW-1:0] res_addr_w [NI];
   logic [AW-1:0] gold_addr_w [NI];
   logic [AW-1:0] fea_w [NI];
   logic [AW:0]   err_w [NI];
   logic [DW-1:0] res_dout_w [NI];
   logic [DW-1:0] gold_dout_w [NI];
   logic [DW-1:0] rq [2];
   logic [DW-1:0] gq [2];

   logic [DW-1:0] res_mem [MEMSZ];
   logic [DW-1:0] gold_mem [MEMSZ];

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      int b;
      int gb;
      int ln;
      int tl;
      int sg;
      int pat;
      int poke;
      int err;
      int first;
      bit fev;
      bit pass;
   } vec_t;

   vec_t tbl [12];

   always #5 clk = ~clk;

   bram_result_checker #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut_lat1 (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .base_addr       (base_addr),
      .gold_base       (gold_base),
      .length          (length),
      .tol             (tol),
      .signed_mode     (signed_mode),
      .res_en          (res_en_w[0]),
      .res_addr        (res_addr_w[0]),
      .res_dout        (res_dout_w[0]),
      .gold_en         (gold_en_w[0]),
      .gold_addr       (gold_addr_w[0]),
      .gold_dout       (gold_dout_w[0]),
      .busy            (busy_w[0]),
      .done            (done_w[0]),
      .pass            (pass_w[0]),
      .err_cnt         (err_w[0]),
      .first_err_valid (fev_w[0]),
      .first_err_addr  (fea_w[0])
   );

   bram_result_checker #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u_dut_lat3 (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .base_addr       (base_addr),
      .gold_base       (gold_base),
      .length          (length),
      .tol             (tol),
      .signed_mode     (signed_mode),
      .res_en          (res_en_w[1]),
      .res_addr        (res_addr_w[1]),
      .res_dout        (res_dout_w[1]),
      .gold_en         (gold_en_w[1]),
      .gold_addr       (gold_addr_w[1]),
      .gold_dout       (gold_dout_w[1]),
      .busy            (busy_w[1]),
      .done            (done_w[1]),
      .pass            (pass_w[1]),
      .err_cnt         (err_w[1]),
      .first_err_valid (fev_w[1]),
      .first_err_addr  (fea_w[1])
   );

   // BRAM models: one-cycle read for instance 0, three-cycle read for instance 1.
   always @(posedge clk) begin
      if (res_en_w[0]) res_dout_w[0] <= res_mem[res_addr_w[0]];
      if (gold_en_w[0]) gold_dout_w[0] <= gold_mem[gold_addr_w[0]];
      if (res_en_w[1]) rq[0] <= res_mem[res_addr_w[1]];
      if (gold_en_w[1]) gq[0] <= gold_mem[gold_addr_w[1]];
      rq[1] <= rq[0];
      gq[1] <= gq[0];
      res_dout_w[1] <= rq[1];
      gold_dout_w[1] <= gq[1];
   end

   task automatic chk(input string name, input int k, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (rd_lat=%0d): got 0x%0h, expected 0x%0h", name, (k == 0) ? 1 : 3,
                  act, exp);
      end
   endtask

   function automatic logic [63:0] outs(input int k);
      return 64'({res_en_w[k], gold_en_w[k], busy_w[k], done_w[k], pass_w[k], fev_w[k],
                  res_addr_w[k], gold_addr_w[k], fea_w[k], err_w[k]});
   endfunction

   // Reference: walk the two regions word by word with plain integer arithmetic.
   function automatic void model(input int b, input int gb, input int ln, input int tl,
                                 input int sg, output int err, output int first,
                                 output bit fev);
      err = 0;
      first = 0;
      fev = 1'b0;
      for (int i = 0; i < ln; i++) begin
         int ra, r, g, d;
         ra = (b + i) % MEMSZ;
         r = int'(res_mem[ra]);
         g = int'(gold_mem[(gb + i) % MEMSZ]);
         if (sg != 0) begin
            if (r > 127) r -= 256;
            if (g > 127) g -= 256;
         end
         d = r - g;
         if (d < 0) d = -d;
         if (d > tl) begin
            err++;
            if (!fev) begin
               fev = 1'b1;
               first = ra;
            end
         end
      end
   endfunction

   task automatic fill_pat(input int b, input int gb, input int ln, input int pat);
      for (int i = 0; i < ln; i++) begin
         res_mem[(b + i) % MEMSZ] = DW'(i);
         gold_mem[(gb + i) % MEMSZ] = DW'(i);
      end
      if (pat == 1) begin
         if (ln > 5) begin
            res_mem[(b + 5) % MEMSZ] = 8'h10;
            gold_mem[(gb + 5) % MEMSZ] = 8'h11;
         end
         if (ln > 200) begin
            res_mem[(b + 200) % MEMSZ] = 8'hAA;
            gold_mem[(gb + 200) % MEMSZ] = 8'h00;
         end
      end else if (pat == 2) begin
         res_mem[b % MEMSZ] = 8'h7F;
         gold_mem[gb % MEMSZ] = 8'h80;
      end
   endtask

   // Called at a falling edge; start is sampled at the next rising edge (T0).
   // Returns in the cycle after the latency-3 instance's done, so the next call
   // issues a back-to-back start.
   task automatic run(input int b, input int gb, input int ln, input int tl, input int sg,
                      input int poke, input int exp_err, input int exp_first,
                      input bit exp_fev, input bit exp_pass, input string tag);
      int done_at [NI];
      int exp_done [NI];
      int last;
      base_addr = AW'(b);
      gold_base = AW'(gb);
      length = (AW + 1)'(ln);
      tol = DW'(tl);
      signed_mode = sg[0];
      start = 1'b1;
      for (int k = 0; k < NI; k++) begin
         done_at[k] = 0;
         exp_done[k] = (ln == 0) ? 1 : ln + ((k == 0) ? 1 : 3) + 1;
      end
      last = exp_done[1] + 1;
      for (int cyc = 1; cyc <= last; cyc++) begin
         @(negedge clk);
         start = (cyc == poke);
         if (cyc == 1) begin
            base_addr = AW'($urandom);
            gold_base = AW'($urandom);
            length = (AW + 1)'($urandom);
            tol = DW'($urandom);
            signed_mode = 1'($urandom);
         end
         for (int k = 0; k < NI; k++) begin
            if (done_w[k] && done_at[k] == 0) done_at[k] = cyc;
            if (cyc <= exp_done[k] + 1) begin
               chk({tag, " busy/done/en"}, k,
                   64'({busy_w[k], done_w[k], res_en_w[k], gold_en_w[k]}),
                   64'({cyc < exp_done[k], cyc == exp_done[k], cyc <= ln, cyc <= ln}));
               if (cyc <= ln) begin
                  chk({tag, " res_addr"}, k, 64'(res_addr_w[k]), 64'((b + cyc - 1) % MEMSZ));
                  chk({tag, " gold_addr"}, k, 64'(gold_addr_w[k]), 64'((gb + cyc - 1) % MEMSZ));
               end
            end
         end
      end
      for (int k = 0; k < NI; k++) begin
         chk({tag, " done cycle"}, k, 64'(done_at[k]), 64'(exp_done[k]));
         chk({tag, " err_cnt"}, k, 64'(err_w[k]), 64'(exp_err));
         chk({tag, " first_err_valid"}, k, 64'(fev_w[k]), 64'(exp_fev));
         chk({tag, " first_err_addr"}, k, 64'(fea_w[k]), 64'(exp_first));
         chk({tag, " pass"}, k, 64'(pass_w[k]), 64'(exp_pass));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e_err, e_first, b, gb, ln, tl, sg, poke;
      bit e_fev;

      //            b     gb   ln   tol sg pat poke err first fev pass
      tbl[0]  = '{0,    0,   294, 0,   0, 0,  0,   0,  0,    0,  1};
      tbl[1]  = '{0,    0,   294, 0,   0, 1,  0,   2,  5,    1,  0};
      tbl[2]  = '{7,    300, 1,   2,   1, 2,  0,   1,  7,    1,  0};
      tbl[3]  = '{7,    300, 1,   2,   0, 2,  0,   0,  0,    0,  1};
      tbl[4]  = '{1022, 0,   4,   0,   0, 0,  0,   0,  0,    0,  1};
      tbl[5]  = '{0,    0,   0,   0,   0, 0,  0,   0,  0,    0,  1};
      tbl[6]  = '{0,    0,   294, 170, 0, 1,  0,   0,  0,    0,  1};
      tbl[7]  = '{0,    0,   294, 169, 0, 1,  0,   1,  200,  1,  0};
      tbl[8]  = '{0,    0,   294, 86,  1, 1,  0,   0,  0,    0,  1};
      tbl[9]  = '{0,    0,   294, 85,  1, 1,  0,   1,  200,  1,  0};
      tbl[10] = '{100,  500, 30,  0,   0, 1,  10,  1,  105,  1,  0};
      tbl[11] = '{0,    0,   1024, 0,  0, 0,  0,   0,  0,    0,  1};

      for (int j = 0; j < MEMSZ; j++) begin
         res_mem[j] = '0;
         gold_mem[j] = '0;
      end

      repeat (2) @(negedge clk);
      for (int k = 0; k < NI; k++) chk("reset values", k, outs(k), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 12; t++) begin
         fill_pat(tbl[t].b, tbl[t].gb, tbl[t].ln, tbl[t].pat);
         run(tbl[t].b, tbl[t].gb, tbl[t].ln, tbl[t].tl, tbl[t].sg, tbl[t].poke, tbl[t].err,
             tbl[t].first, tbl[t].fev, tbl[t].pass, $sformatf("vec%0d", t));
      end

      // Reset in the middle of a sweep abandons it without a done pulse.
      fill_pat(40, 40, 8, 0);
      base_addr = AW'(40);
      gold_base = AW'(40);
      length = (AW + 1)'(8);
      tol = '0;
      signed_mode = 1'b0;
      start = 1'b1;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) chk("mid-run reset outputs", k, outs(k), 64'd0);
      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) chk("held in reset", k, outs(k), 64'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NI; k++) chk("after reset release", k, outs(k), 64'd0);
      model(40, 40, 8, 0, 0, e_err, e_first, e_fev);
      run(40, 40, 8, 0, 0, 0, e_err, e_first, e_fev, e_err == 0, "post-reset");

      // Randomised sweeps against the reference model.
      for (int r = 0; r < 20; r++) begin
         for (int j = 0; j < MEMSZ; j++) begin
            res_mem[j] = DW'($urandom);
            gold_mem[j] = DW'($urandom);
         end
         b = int'($urandom_range(0, MEMSZ - 1));
         gb = int'($urandom_range(0, MEMSZ - 1));
         ln = int'($urandom_range(0, 60));
         tl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                          : int'($urandom_range(0, 4));
         sg = int'($urandom_range(0, 1));
         poke = (ln > 4) ? int'($urandom_range(2, ln)) : 0;
         for (int i = 0; i < ln; i++) begin
            if ($urandom_range(0, 3) != 0) begin
               gold_mem[(gb + i) % MEMSZ] = res_mem[(b + i) % MEMSZ]
                                            + DW'($urandom_range(0, 6)) - 8'd3;
            end
         end
         model(b, gb, ln, tl, sg, e_err, e_first, e_fev);
         run(b, gb, ln, tl, sg, poke, e_err, e_first, e_fev, e_err == 0,
             $sformatf("rand%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
